// File: rtl/mul_sched_if.sv
// ---------------------------------------------------------------------------
// mul_sched_if
//
// Bundles every handshake and data signal of the shared multiplier scheduler:
// the per-requester request channel, the operand/result path to the pipelined
// multiplier, the response channel and the busy flag.
//
//   slave  : the scheduler's view (mul_sched uses this modport)
//   master : the environment's view (requesters, multiplier, response sink)
//
// Signal summary:
//   req_valid  [NREQ]        request valid, one bit per requester
//   req_ready  [NREQ]        one-hot accept (or zero)
//   req_signed [NREQ]        signed-multiply select per requester
//   req_x/y    [NREQ*32]     operands, requester i in bits [32i+31:32i]
//   mul_signed/mul_x/mul_y   operands forwarded to the multiplier
//   mul_result [64]          product returned by the multiplier
//   resp_valid/resp_ready    response handshake (head of response FIFO)
//   resp_id    [IDW]         requester id of the head entry
//   resp_result[64]          product of the head entry
//   busy                     any operation in flight or buffered
// ---------------------------------------------------------------------------
interface mul_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_signed;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ*32-1:0] req_y;

    logic               mul_signed;
    logic [31:0]        mul_x;
    logic [31:0]        mul_y;
    logic [63:0]        mul_result;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [63:0]        resp_result;

    logic               busy;

    modport slave (
        input  req_valid, req_signed, req_x, req_y, mul_result, resp_ready,
        output req_ready, mul_signed, mul_x, mul_y,
        output resp_valid, resp_id, resp_result, busy
    );

    modport master (
        output req_valid, req_signed, req_x, req_y, mul_result, resp_ready,
        input  req_ready, mul_signed, mul_x, mul_y,
        input  resp_valid, resp_id, resp_result, busy
    );
endinterface

// File: rtl/mul_sched.sv
// ---------------------------------------------------------------------------
// mul_sched
//
// Round-robin scheduler sharing one pipelined 32x32 multiplier between NREQ
// requesters. At most one operation is issued per cycle. The requester id of
// each issued operation travels down a shift pipe matched to the multiplier
// latency; when the pipe tail is valid, the product and id are written into a
// first-word-fall-through response FIFO. Issue is gated by a credit check so
// that everything in flight plus everything buffered always fits the FIFO.
//
// Ports:
//   mul_clk  clock, all state updates on the rising edge
//   resetn   asynchronous active-low reset; discards in-flight and buffered
//            results and forces all outputs to zero while asserted
//   bus      mul_sched_if.slave (request, multiplier and response channels)
//
// Parameters:
//   NREQ        number of requesters (2..4)
//   IDW         requester id width, ceil(log2(NREQ)), minimum 1
//   MUL_LAT     cycles from issue to valid multiplier result
//   FIFO_DEPTH  response FIFO entries, power of 2, >= MUL_LAT+1
// ---------------------------------------------------------------------------
module mul_sched #(
    parameter int NREQ       = 2,
    parameter int IDW        = 1,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       mul_clk,
    input  logic       resetn,
    mul_sched_if.slave bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int XW = $clog2(NREQ * 32);
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    // Arbitration state
    logic [IDW-1:0]  rr_ptr;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic            issue;
    logic [XW-1:0]   op_base;

    // In-flight tracking
    logic [MUL_LAT-1:0] pipe_vld;
    logic [IDW-1:0]     pipe_id [MUL_LAT];
    logic               retire;
    logic [CW-1:0]      inflight_cnt;

    // Response FIFO
    logic [IDW-1:0]  fifo_id   [FIFO_DEPTH];
    logic [63:0]     fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   fifo_count;
    logic            push;
    logic            pop;
    logic            fifo_nonempty;

    // Credit check
    logic [CW:0]     credit_used;
    logic            issue_ok;

    // Credits use only registered counts; a pop in this cycle is not
    // credited until the next one, which keeps the ready path short.
    assign credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_count};
    assign issue_ok    = (credit_used < DEPTH_C);

    // Search req_valid starting at the round-robin pointer, wrapping.
    always_comb begin : arbiter
        int             idx;
        logic [IDW-1:0] idx_v;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        idx_v       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = IDW'(idx);
            if (!grant_found && bus.req_valid[idx_v]) begin
                grant_found = 1'b1;
                grant_id    = idx_v;
            end
        end
    end

    // resetn gates the combinational issue path so ready and the multiplier
    // operands read zero for the whole time reset is held.
    assign issue   = grant_found & issue_ok & resetn;
    assign op_base = XW'(grant_id) << 5;

    always_comb begin
        bus.req_ready  = '0;
        bus.mul_x      = '0;
        bus.mul_y      = '0;
        bus.mul_signed = 1'b0;
        if (issue) begin
            bus.req_ready  = NREQ'(1) << grant_id;
            bus.mul_x      = bus.req_x[op_base +: 32];
            bus.mul_y      = bus.req_y[op_base +: 32];
            bus.mul_signed = bus.req_signed[grant_id];
        end
    end

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // The pipe tail marks the cycle in which mul_result belongs to that id.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_id[0]  <= grant_id;
            for (int s = 1; s < MUL_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    assign retire        = pipe_vld[MUL_LAT-1];
    assign push          = retire;
    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = fifo_nonempty & bus.resp_ready;

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            inflight_cnt <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    // Credits guarantee push never meets a full FIFO, so no full check here.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge mul_clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= pipe_id[MUL_LAT-1];
            fifo_data[wr_ptr] <= bus.mul_result;
        end
    end

    assign bus.resp_valid  = fifo_nonempty;
    assign bus.resp_id     = fifo_nonempty ? fifo_id[rd_ptr]   : '0;
    assign bus.resp_result = fifo_nonempty ? fifo_data[rd_ptr] : '0;
    assign bus.busy        = (inflight_cnt != '0) | fifo_nonempty;

endmodule
